// File: rtl/fir_channel_scheduler_if.sv
// Handshake bundle between the frame-tick source, fir_channel_scheduler and the filter bank.
// The scheduler connects through the slave modport; the tick/filter side uses master.
interface fir_channel_scheduler_if #(
  parameter int unsigned NUM_CH = 4
);
  localparam int unsigned CW = $clog2(NUM_CH) + 1;

  logic              tick_i;
  logic [NUM_CH-1:0] ch_enable_i;
  logic [NUM_CH-1:0] done_i;
  logic              clear_i;
  logic [NUM_CH-1:0] start_o;
  logic [CW-1:0]     active_ch_o;
  logic              busy_o;
  logic              frame_done_o;
  logic [31:0]       frame_count_o;
  logic              overrun_o;
  logic              timeout_o;

  modport slave (
    input  tick_i, ch_enable_i, done_i, clear_i,
    output start_o, active_ch_o, busy_o, frame_done_o, frame_count_o, overrun_o, timeout_o
  );

  modport master (
    output tick_i, ch_enable_i, done_i, clear_i,
    input  start_o, active_ch_o, busy_o, frame_done_o, frame_count_o, overrun_o, timeout_o
  );
endinterface

// File: rtl/fir_channel_scheduler.sv
// Delays each ADC frame tick, then starts every enabled FIR channel in index order, one at a time.
// Define SCHED_TIMEOUT_EN to abandon a channel whose done_i is absent for TIMEOUT_CYCLES cycles.
module fir_channel_scheduler #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned DELAY_CYCLES   = 100,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                   clk_i,
  input  logic                   reset,
  fir_channel_scheduler_if.slave bus
);
  localparam int unsigned CW = $clog2(NUM_CH) + 1;
  localparam int unsigned DW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DELAY,
    S_ISSUE,
    S_WAIT,
    S_FINISH
  } state_e;

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [CW-1:0]     ch_q, ch_d;
  logic [DW-1:0]     dly_q, dly_d;
  logic [31:0]       frame_cnt_q, frame_cnt_d;
  logic              overrun_q, overrun_d;

  logic [NUM_CH-1:0] sel_mask;
  logic              done_hit;
  logic              accept;
  logic [CW:0]       pend_low;
  logic [CW:0]       en_low;

  // {found, index} of the lowest set bit
  function automatic logic [CW:0] lowest(input logic [NUM_CH-1:0] m);
    logic [CW:0] r;
    r = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (m[i] && !r[CW]) r = {1'b1, CW'(i)};
    end
    return r;
  endfunction

  assign sel_mask = NUM_CH'(1) << ch_q;
  assign done_hit = |(bus.done_i & sel_mask);
  assign pend_low = lowest(pend_q);
  assign en_low   = lowest(bus.ch_enable_i);
  assign accept   = bus.tick_i && (state_q == S_IDLE || state_q == S_FINISH);

`ifdef SCHED_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          timeout_q, timeout_d;
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    ch_d        = ch_q;
    dly_d       = dly_q;
    frame_cnt_d = frame_cnt_q;
    overrun_d   = overrun_q & ~bus.clear_i;
`ifdef SCHED_TIMEOUT_EN
    tmo_d       = tmo_q;
    timeout_d   = timeout_q & ~bus.clear_i;
`endif

    unique case (state_q)
      S_IDLE: ;
      // The pending mask empties only when nothing was enabled, so the zero-count
      // exit is the empty-frame path and lands one cycle after the start slot.
      S_DELAY: begin
        if (dly_q == DW'(1) && pend_low[CW]) begin
          state_d = S_ISSUE;
          ch_d    = pend_low[CW-1:0];
        end else if (dly_q == '0) begin
          state_d = S_FINISH;
        end else begin
          dly_d = dly_q - DW'(1);
        end
      end
      S_ISSUE: begin
        pend_d  = pend_q & ~sel_mask;
        state_d = S_WAIT;
`ifdef SCHED_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      S_WAIT: begin
        if (done_hit) begin
          state_d = pend_low[CW] ? S_ISSUE : S_FINISH;
          ch_d    = pend_low[CW] ? pend_low[CW-1:0] : ch_q;
`ifdef SCHED_TIMEOUT_EN
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          state_d   = pend_low[CW] ? S_ISSUE : S_FINISH;
          ch_d      = pend_low[CW] ? pend_low[CW-1:0] : ch_q;
        end else begin
          tmo_d = tmo_q + TW'(1);
`endif
        end
      end
      S_FINISH: begin
        frame_cnt_d = frame_cnt_q + 32'd1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      pend_d = bus.ch_enable_i;
      dly_d  = DW'(DELAY_CYCLES - 1);
      // A one-cycle delay leaves no room for a DELAY state before the start slot.
      if (DELAY_CYCLES == 1 && en_low[CW]) begin
        state_d = S_ISSUE;
        ch_d    = en_low[CW-1:0];
      end else begin
        state_d = S_DELAY;
      end
    end else if (bus.tick_i) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pend_q      <= '0;
      ch_q        <= '0;
      dly_q       <= '0;
      frame_cnt_q <= '0;
      overrun_q   <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
      tmo_q       <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      ch_q        <= ch_d;
      dly_q       <= dly_d;
      frame_cnt_q <= frame_cnt_d;
      overrun_q   <= overrun_d;
`ifdef SCHED_TIMEOUT_EN
      tmo_q       <= tmo_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  // Pulses are masked by reset so an aborted frame emits nothing in the reset cycle.
  assign bus.start_o       = (state_q == S_ISSUE && !reset) ? sel_mask : '0;
  assign bus.frame_done_o  = (state_q == S_FINISH) && !reset;
  assign bus.active_ch_o   = (state_q == S_ISSUE || state_q == S_WAIT) ? ch_q : '0;
  assign bus.busy_o        = (state_q != S_IDLE);
  assign bus.frame_count_o = frame_cnt_q;
  assign bus.overrun_o     = overrun_q;
`ifdef SCHED_TIMEOUT_EN
  assign bus.timeout_o     = timeout_q;
`else
  assign bus.timeout_o     = 1'b0;
`endif
endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Scoreboard bench for fir_channel_scheduler: expected start/frame_done events are queued by the
// stimulus and popped by a monitor; a responder returns done_i a fixed latency after each start.
module tb_fir_channel_scheduler;
  logic clk = 1'b0;
  logic reset;
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  int   fc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fir_channel_scheduler_if #(.NUM_CH(4)) bus ();

  fir_channel_scheduler #(
    .NUM_CH        (4),
    .DELAY_CYCLES  (100),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int          cyc;
    logic [3:0]  start;
    logic        fdone;
    logic [31:0] cnt;
    logic [2:0]  ach;
  } ev_t;

  ev_t sbq[$];
  ev_t mon_e;

  logic [3:0] resp_done  = '0;
  logic [3:0] stray_done = '0;
  logic [3:0] resp_mask  = 4'hF;
  int         resp_lat   = 3;

  assign bus.done_i = resp_done | stray_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic goto(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick_at(input int k);
    goto(k);
    bus.tick_i = 1'b1;
    goto(k + 1);
    bus.tick_i = 1'b0;
  endtask

  task automatic exp_start(input int c, input int ch);
    ev_t e;
    e = '{c, 4'(1 << ch), 1'b0, 32'd0, 3'(ch)};
    sbq.push_back(e);
  endtask

  task automatic exp_done(input int c);
    ev_t e;
    e = '{c, 4'd0, 1'b1, 32'(fc), 3'd0};
    sbq.push_back(e);
    fc++;
  endtask

  task automatic drain(input string name);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL %s: got %0d events still pending expected 0", name, sbq.size());
      sbq.delete();
    end
  endtask

  // Filter-bank model: done for the started channel resp_lat cycles after its start.
  initial begin
    logic [3:0] s;
    forever begin
      @(negedge clk);
      if ((bus.start_o & resp_mask) != '0) begin
        s = bus.start_o;
        repeat (resp_lat) @(posedge clk);
        #1 resp_done = s;
        @(posedge clk);
        #1 resp_done = '0;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.start_o != '0 || bus.frame_done_o) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got start_o=%b frame_done_o=%b at cycle %0d expected no event",
                 bus.start_o, bus.frame_done_o, cyc);
      end else begin
        mon_e = sbq.pop_front();
        chk("ev_cycle", 32'(cyc), 32'(mon_e.cyc));
        chk("ev_start_o", 32'(bus.start_o), 32'(mon_e.start));
        chk("ev_frame_done", 32'(bus.frame_done_o), 32'(mon_e.fdone));
        if (mon_e.fdone) chk("ev_frame_count", bus.frame_count_o, mon_e.cnt);
        else             chk("ev_active_ch", 32'(bus.active_ch_o), 32'(mon_e.ach));
      end
    end
  end

  initial begin
    int b;
    reset           = 1'b1;
    bus.tick_i      = 1'b0;
    bus.ch_enable_i = '0;
    bus.clear_i     = 1'b0;
    goto(3);
    reset = 1'b0;
    goto(4);
    chk("reset_busy", 32'(bus.busy_o), 0);
    chk("reset_start", 32'(bus.start_o), 0);
    chk("reset_count", bus.frame_count_o, 0);
    chk("reset_overrun", 32'(bus.overrun_o), 0);
    chk("reset_timeout", 32'(bus.timeout_o), 0);
    chk("reset_active", 32'(bus.active_ch_o), 0);

    // All four channels, done 3 cycles after each start
    b = 10;
    bus.ch_enable_i = 4'hF;
    exp_start(b + 100, 0); exp_start(b + 104, 1); exp_start(b + 108, 2); exp_start(b + 112, 3);
    exp_done(b + 116);
    goto(b);
    chk("idle_busy", 32'(bus.busy_o), 0);
    tick_at(b);
    chk("busy_after_tick", 32'(bus.busy_o), 1);
    goto(b + 120);
    chk("t1_count", bus.frame_count_o, 1);
    drain("t1_drain");

    // Sparse enable 0101, then an empty frame
    b = 140;
    bus.ch_enable_i = 4'b0101;
    exp_start(b + 100, 0); exp_start(b + 104, 2); exp_done(b + 108);
    tick_at(b);
    goto(b + 112);
    chk("t2_count", bus.frame_count_o, 2);
    drain("t2_drain");

    b = 260;
    bus.ch_enable_i = 4'b0000;
    exp_done(b + 101);
    tick_at(b);
    goto(b + 100);
    chk("t2b_busy_at_100", 32'(bus.busy_o), 1);
    goto(b + 103);
    chk("t2b_busy_end", 32'(bus.busy_o), 0);
    chk("t2b_count", bus.frame_count_o, 3);
    drain("t2b_drain");

    // Overrun while waiting; set wins over simultaneous clear; clear alone drops it
    b = 370;
    bus.ch_enable_i = 4'hF;
    exp_start(b + 100, 0); exp_start(b + 104, 1); exp_start(b + 108, 2); exp_start(b + 112, 3);
    exp_done(b + 116);
    tick_at(b);
    goto(b + 104);
    chk("t3_overrun_before", 32'(bus.overrun_o), 0);
    tick_at(b + 105);
    chk("t3_overrun_set", 32'(bus.overrun_o), 1);
    goto(b + 109);
    bus.clear_i = 1'b1;
    bus.tick_i  = 1'b1;
    goto(b + 110);
    bus.clear_i = 1'b0;
    bus.tick_i  = 1'b0;
    chk("t3_set_wins_clear", 32'(bus.overrun_o), 1);
    goto(b + 118);
    chk("t3_count", bus.frame_count_o, 4);
    drain("t3_drain");
    bus.clear_i = 1'b1;
    goto(b + 119);
    bus.clear_i = 1'b0;
    chk("t3_overrun_cleared", 32'(bus.overrun_o), 0);

    // Tick in FINISH cycle; enable changes mid-frame; stray done[3] while on ch0
    b = 500;
    bus.ch_enable_i = 4'b0001;
    exp_start(b + 100, 0); exp_done(b + 104);
    exp_start(b + 204, 0); exp_start(b + 208, 3); exp_done(b + 212);
    tick_at(b);
    goto(b + 50);
    bus.ch_enable_i = 4'b1001;
    tick_at(b + 104);
    chk("t4_busy_after_finish_tick", 32'(bus.busy_o), 1);
    goto(b + 150);
    bus.ch_enable_i = 4'hF;
    goto(b + 205);
    stray_done = 4'b1000;
    goto(b + 206);
    stray_done = '0;
    goto(b + 214);
    chk("t4_overrun", 32'(bus.overrun_o), 0);
    chk("t4_count", bus.frame_count_o, 6);
    drain("t4_drain");

`ifdef SCHED_TIMEOUT_EN
    // ch1 never answers: abandoned 9 cycles after its start
    b = 730;
    bus.ch_enable_i = 4'b0111;
    resp_mask = 4'b1101;
    exp_start(b + 100, 0); exp_start(b + 104, 1); exp_start(b + 113, 2); exp_done(b + 117);
    tick_at(b);
    goto(b + 112);
    chk("t5_timeout_not_yet", 32'(bus.timeout_o), 0);
    goto(b + 114);
    chk("t5_timeout_set", 32'(bus.timeout_o), 1);
    goto(b + 119);
    chk("t5_count", bus.frame_count_o, 7);
    drain("t5_drain");
    resp_mask = 4'hF;
    bus.clear_i = 1'b1;
    goto(b + 120);
    bus.clear_i = 1'b0;
    chk("t5_timeout_cleared", 32'(bus.timeout_o), 0);

    // done exactly at start+8 is accepted
    b = 860;
    bus.ch_enable_i = 4'b0011;
    resp_lat = 8;
    exp_start(b + 100, 0); exp_start(b + 109, 1); exp_done(b + 118);
    tick_at(b);
    goto(b + 120);
    chk("t5b_no_timeout", 32'(bus.timeout_o), 0);
    chk("t5b_count", bus.frame_count_o, 8);
    drain("t5b_drain");
    resp_lat = 3;
`endif

    // Reset in the ISSUE cycle aborts with no pulse; fresh tick restarts from zero
    b = 1000;
    bus.ch_enable_i = 4'hF;
    tick_at(b);
    tick_at(b + 50);
    chk("t6_overrun_set", 32'(bus.overrun_o), 1);
    goto(b + 100);
    reset = 1'b1;
    goto(b + 101);
    reset = 1'b0;
    chk("t6_busy", 32'(bus.busy_o), 0);
    chk("t6_start", 32'(bus.start_o), 0);
    chk("t6_overrun", 32'(bus.overrun_o), 0);
    chk("t6_count", bus.frame_count_o, 0);
    chk("t6_active", 32'(bus.active_ch_o), 0);
    drain("t6_drain_abort");
    fc = 0;
    b = 1110;
    bus.ch_enable_i = 4'b0001;
    exp_start(b + 100, 0); exp_done(b + 104);
    tick_at(b);
    goto(b + 106);
    chk("t6_restart_count", bus.frame_count_o, 1);
    drain("t6_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
